mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, default 32, width of retired-instruction counter.
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: inst  in  32  current IR contents from datapath; alu_zero  in  1  ALU equality result.
REQ-005 SHALL have ports: mem_req  out  1  bus request; mem_we  out  1  bus write; mem_gnt  in  1  transfer done (read data valid same cycle).
REQ-006 SHALL have ports: ir_we  out  1; pc_we  out  1; pc_sel  out  2  (0=pc+4, 1=branch target, 2=jump target); alu_src_imm  out  1.
REQ-007 SHALL have ports: rf_wen  out  1; rf_waddr  out  5; wb_sel  out  1  (0=ALU, 1=memory) -- register-file write port drive.
REQ-008 SHALL have ports: illegal  out  1  one-cycle unknown-opcode pulse; retired  out  CNT_WIDTH  retired-instruction count; state  out  3  debug.

Function
REQ-009 SHALL implement FSM states IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 unreachable, decode to IF.
REQ-010 SHALL support opcodes: R-type 0x00, addiu 0x09, lw 0x23, sw 0x2B, beq 0x04, j 0x02; all others illegal.
REQ-011 IF: mem_req=1, mem_we=0; hold until mem_gnt=1; in gnt cycle ir_we=1, pc_we=1, pc_sel=0; next state ID.
REQ-012 mem_req SHALL stay asserted every IF/MEM cycle until mem_gnt; no timeout.
REQ-013 ID: all strobes 0; next state EX unconditionally.
REQ-014 EX, R-type/addiu: next WB; alu_src_imm=1 for addiu only.
REQ-015 EX, lw/sw: alu_src_imm=1; next MEM.
REQ-016 EX, beq: pc_we=alu_zero, pc_sel=1; next IF; instruction retires.
REQ-017 EX, j: pc_we=1, pc_sel=2; next IF; instruction retires.
REQ-018 EX, illegal: illegal=1 one cycle; next IF; not retired.
REQ-019 MEM: mem_req=1, mem_we=1 for sw else 0; on mem_gnt sw goes IF (retires), lw goes WB.
REQ-020 WB: rf_waddr=inst[15:11] for R-type, inst[20:16] otherwise; wb_sel=1 for lw only; next IF; retires.
REQ-021 WB: rf_wen=1 iff rf_waddr!=0; rf_wen=0 in all other states.
REQ-022 rf_wen SHALL be high exactly one cycle per register-writing instruction.
REQ-023 retired SHALL increment by 1 in the cycle after each retiring transition; wraps all-ones to 0.
REQ-024 Outputs SHALL be combinational from state, inst, alu_zero, mem_gnt; no output-to-input combinational loop.
REQ-025 Latency: R/addiu 4 cycles, lw 5, sw 4, beq/j 3, with mem_gnt same cycle as mem_req.

Reset
REQ-026 While rst=1, every output SHALL be 0 and mem_req forced 0 regardless of state.
REQ-027 rst=1 at clock edge SHALL set state=IF, retired=0, overriding any transition in that cycle.
REQ-028 Reset mid-handshake SHALL abandon the transfer; first cycle after rst deasserts asserts mem_req in IF.
REQ-029 mem_gnt while rst=1 SHALL be ignored.

Structure
REQ-030 Package mips_pkg SHALL hold opcode constants, state encoding, pc_sel encoding.
REQ-031 Opcode decode SHALL be one combinational sub-module mc_decode (inst -> class, dest select, illegal).
REQ-032 retired counter and FSM register SHALL live in mips_mc_ctrl.

Verification
REQ-033 addiu $t0,$0,5 (0x24080005), gnt immediate -> IF,ID,EX,WB; WB rf_wen=1, rf_waddr=8, wb_sel=0; retired 0->1.
REQ-034 lw $9,0($0) with MEM gnt delayed 3 cycles -> mem_req high 4 MEM cycles, mem_we=0; then WB rf_waddr=9, wb_sel=1.
REQ-035 beq alu_zero=1 -> EX pc_we=1, pc_sel=1; alu_zero=0 -> pc_we=0; both next IF, retired +1 each.
REQ-036 opcode 0x3F -> illegal=1 one cycle in EX, retired unchanged; R-type rd=0 (0x00000000) -> rf_wen=0 in WB.
REQ-037 rst pulse during MEM wait of sw -> outputs 0 in rst cycle, state=IF, retired=0; no write observed.
REQ-038 retired preset near all-ones via CNT_WIDTH=4, 17 retirements -> wraps, reads 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// PC source select and the decoded instruction class.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_JMP = 2'd2;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDIU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_ILLEGAL
    } inst_class_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Memory bus handshake between the controller and the shared instruction/data memory.
interface mips_mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_gnt;

    modport master (output mem_req, output mem_we, input mem_gnt);
    modport slave  (input mem_req, input mem_we, output mem_gnt);
endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational opcode decode: instruction class, destination register and
// illegal-opcode flag.
module mc_decode
    import mips_pkg::*;
(
    input  logic [31:0]  inst,
    output inst_class_t  inst_class,
    output logic [4:0]   dest,
    output logic         is_illegal
);

    logic unused_fields;
    assign unused_fields = ^{inst[25:21], inst[10:0]};

    always_comb begin
        inst_class = CLS_ILLEGAL;
        case (inst[31:26])
            OP_RTYPE: inst_class = CLS_RTYPE;
            OP_ADDIU: inst_class = CLS_ADDIU;
            OP_LW:    inst_class = CLS_LW;
            OP_SW:    inst_class = CLS_SW;
            OP_BEQ:   inst_class = CLS_BEQ;
            OP_J:     inst_class = CLS_J;
            default:  inst_class = CLS_ILLEGAL;
        endcase
    end

    // R-type writes rd, everything else that writes uses rt
    assign dest       = (inst_class == CLS_RTYPE) ? inst[15:11] : inst[20:16];
    assign is_illegal = (inst_class == CLS_ILLEGAL);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with retired-instruction counter.
// All outputs are combinational from state and inputs, forced to zero during reset.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst,
    input  logic                 alu_zero,
    mips_mc_ctrl_if.master       mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 alu_src_imm,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic                 wb_sel,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [2:0]           state
);

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  retired_reg;
    inst_class_t           inst_class;
    logic [4:0]            dest;
    logic                  dec_illegal;

    logic       req_c, we_c, ir_we_c, pc_we_c, imm_c, rf_wen_c, wb_sel_c, ill_c, retire_c;
    logic [1:0] pc_sel_c;
    logic [4:0] waddr_c;

    mc_decode u_decode (
        .inst       (inst),
        .inst_class (inst_class),
        .dest       (dest),
        .is_illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IF;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire_c)
                retired_reg <= retired_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_c      = 1'b0;
        we_c       = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = PC_SEL_SEQ;
        imm_c      = 1'b0;
        rf_wen_c   = 1'b0;
        waddr_c    = 5'd0;
        wb_sel_c   = 1'b0;
        ill_c      = 1'b0;
        retire_c   = 1'b0;
        case (state_reg)
            ST_IF: begin
                req_c = 1'b1;
                if (mem.mem_gnt) begin
                    ir_we_c    = 1'b1;
                    pc_we_c    = 1'b1;
                    state_next = ST_ID;
                end
            end
            ST_ID: state_next = ST_EX;
            ST_EX: begin
                case (inst_class)
                    CLS_RTYPE: state_next = ST_WB;
                    CLS_ADDIU: begin
                        imm_c      = 1'b1;
                        state_next = ST_WB;
                    end
                    CLS_LW, CLS_SW: begin
                        imm_c      = 1'b1;
                        state_next = ST_MEM;
                    end
                    CLS_BEQ: begin
                        pc_we_c    = alu_zero;
                        pc_sel_c   = PC_SEL_BR;
                        retire_c   = 1'b1;
                        state_next = ST_IF;
                    end
                    CLS_J: begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = PC_SEL_JMP;
                        retire_c   = 1'b1;
                        state_next = ST_IF;
                    end
                    default: begin
                        ill_c      = dec_illegal;
                        state_next = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                req_c = 1'b1;
                we_c  = (inst_class == CLS_SW);
                if (mem.mem_gnt) begin
                    if (inst_class == CLS_SW) begin
                        retire_c   = 1'b1;
                        state_next = ST_IF;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                waddr_c    = dest;
                rf_wen_c   = (dest != 5'd0);
                wb_sel_c   = (inst_class == CLS_LW);
                retire_c   = 1'b1;
                state_next = ST_IF;
            end
            default: state_next = ST_IF;
        endcase
    end

    assign mem.mem_req = req_c & ~rst;
    assign mem.mem_we  = we_c & ~rst;
    assign ir_we       = ir_we_c & ~rst;
    assign pc_we       = pc_we_c & ~rst;
    assign pc_sel      = rst ? 2'd0 : pc_sel_c;
    assign alu_src_imm = imm_c & ~rst;
    assign rf_wen      = rf_wen_c & ~rst;
    assign rf_waddr    = rst ? 5'd0 : waddr_c;
    assign wb_sel      = wb_sel_c & ~rst;
    assign illegal     = ill_c & ~rst;
    assign retired     = rst ? '0 : retired_reg;
    assign state       = rst ? 3'd0 : state_reg;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through the FSM,
// exercises memory wait states, reset mid-transfer and counter wrap (CNT_WIDTH=4).
module tb_mips_mc_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   inst;
    logic          alu_zero;
    logic          ir_we, pc_we, alu_src_imm, rf_wen, wb_sel, illegal;
    logic [1:0]    pc_sel;
    logic [4:0]    rf_waddr;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst        (inst),
        .alu_zero    (alu_zero),
        .mem         (bus),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .alu_src_imm (alu_src_imm),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .illegal     (illegal),
        .retired     (retired),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // advance to the next falling edge, apply inputs, let outputs settle
    task automatic cyc(input logic gnt, input logic zero);
        @(negedge clk);
        bus.mem_gnt = gnt;
        alu_zero    = zero;
        #1;
    endtask

    // IF with immediate grant, IR loads word; then ID
    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_ret);
        cyc(1'b1, 1'b0);
        chk("if_state",   32'(state),       32'd0);
        chk("if_req",     32'(bus.mem_req), 32'd1);
        chk("if_irwe_pc", 32'({ir_we, pc_we, pc_sel, bus.mem_we}), 32'b11000);
        chk("retired",    32'(retired),     exp_ret);
        inst = word;
        cyc(1'b0, 1'b0);
        chk("id_state",   32'(state), 32'd1);
        chk("id_strobes", 32'({ir_we, pc_we, bus.mem_req, rf_wen, illegal}), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        inst        = 32'd0;
        alu_zero    = 1'b0;
        bus.mem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        bus.mem_gnt = 1'b1;
        #1;
        chk("rst_state",   32'(state),       32'd0);
        chk("rst_req",     32'(bus.mem_req), 32'd0);
        chk("rst_retired", 32'(retired),     32'd0);
        chk("rst_irwe",    32'(ir_we),       32'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_gnt = 1'b0;
        #1;
        chk("rel_req", 32'(bus.mem_req), 32'd1);

        // addiu $t0,$0,5
        fetch(32'h24080005, 32'd0);
        cyc(1'b0, 1'b0);
        chk("addiu_ex_state", 32'(state),       32'd2);
        chk("addiu_ex_imm",   32'(alu_src_imm), 32'd1);
        cyc(1'b0, 1'b0);
        chk("addiu_wb_state", 32'(state), 32'd4);
        chk("addiu_wb",       32'({rf_wen, rf_waddr, wb_sel}), {25'd0, 1'b1, 5'd8, 1'b0});

        // lw $9,0($0) with three wait cycles
        fetch(32'h8C090000, 32'd1);
        cyc(1'b0, 1'b0);
        chk("lw_ex_imm", 32'(alu_src_imm), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 1'b0);
            chk("lw_mem_state", 32'(state),                   32'd3);
            chk("lw_mem_req",   32'({bus.mem_req, bus.mem_we}), 32'b10);
        end
        cyc(1'b0, 1'b0);
        chk("lw_wb", 32'({state, rf_wen, rf_waddr, wb_sel}), {22'd0, 3'd4, 1'b1, 5'd9, 1'b1});

        // beq taken / not taken
        fetch(32'h10000000, 32'd2);
        cyc(1'b0, 1'b1);
        chk("beq1_ex", 32'({state, pc_we, pc_sel}), {26'd0, 3'd2, 1'b1, 2'd1});
        fetch(32'h10000000, 32'd3);
        cyc(1'b0, 1'b0);
        chk("beq0_ex", 32'({state, pc_we, pc_sel}), {26'd0, 3'd2, 1'b0, 2'd1});

        // j
        fetch(32'h08000000, 32'd4);
        cyc(1'b0, 1'b0);
        chk("j_ex", 32'({pc_we, pc_sel}), 32'b110);

        // sw with immediate grant
        fetch(32'hAC090000, 32'd5);
        cyc(1'b0, 1'b0);
        chk("sw_ex_imm", 32'(alu_src_imm), 32'd1);
        cyc(1'b1, 1'b0);
        chk("sw_mem", 32'({state, bus.mem_req, bus.mem_we, rf_wen}), {27'd0, 3'd3, 3'b110});

        // illegal opcode 0x3F
        fetch(32'hFC000000, 32'd6);
        cyc(1'b0, 1'b0);
        chk("ill_ex", 32'({state, illegal, pc_we}), {27'd0, 3'd2, 2'b10});

        // R-type rd=0: no register write; retired unchanged by the illegal op
        fetch(32'h00000000, 32'd6);
        cyc(1'b0, 1'b0);
        chk("r0_ex", 32'({illegal, alu_src_imm}), 32'd0);
        cyc(1'b0, 1'b0);
        chk("r0_wb", 32'({state, rf_wen}), {28'd0, 3'd4, 1'b0});

        // R-type rd=5
        fetch(32'h00002820, 32'd7);
        cyc(1'b0, 1'b0);
        chk("r5_ex_imm", 32'(alu_src_imm), 32'd0);
        cyc(1'b0, 1'b0);
        chk("r5_wb", 32'({rf_wen, rf_waddr, wb_sel}), {25'd0, 1'b1, 5'd5, 1'b0});

        // reset during sw memory wait
        fetch(32'hAC090000, 32'd8);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("swr_mem", 32'({state, bus.mem_req, bus.mem_we}), {27'd0, 3'd3, 2'b11});
        @(negedge clk);
        rst         = 1'b1;
        bus.mem_gnt = 1'b1;
        #1;
        chk("swr_rst_out", 32'({bus.mem_req, bus.mem_we, rf_wen, pc_we, ir_we}), 32'd0);
        chk("swr_rst_st",  32'({state, retired}), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_gnt = 1'b0;
        #1;
        chk("swr_after", 32'({state, bus.mem_req, bus.mem_we, retired}), {25'd0, 3'd0, 2'b10, 4'd0});

        // 17 jumps wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            fetch(32'h08000000, 32'(i % 16));
            cyc(1'b0, 1'b0);
            chk("wrap_j_ex", 32'({state, pc_sel}), {27'd0, 3'd2, 2'd2});
        end
        cyc(1'b0, 1'b0);
        chk("wrap_final", 32'({state, retired}), {25'd0, 3'd0, 4'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
